// File: rtl/mul2x2_seq_ctrl.sv
// Sequential W x W unsigned multiplier. One 2x2 partial product is issued per
// clock and shift-accumulated into a 2W-bit result. Valid/ready handshakes on
// both the operand side and the result side.

// 2x2 unsigned multiplier built from half-adder logic.
module mul2x2_top (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic w_a1b0;
    logic w_a0b1;
    logic w_a1b1;
    logic w_c1;

    assign w_a1b0 = a[1] & b[0];
    assign w_a0b1 = a[0] & b[1];
    assign w_a1b1 = a[1] & b[1];
    assign w_c1   = w_a1b0 & w_a0b1;

    assign p[0] = a[0] & b[0];
    assign p[1] = w_a1b0 ^ w_a0b1;
    assign p[2] = w_a1b1 ^ w_c1;
    assign p[3] = w_a1b1 & w_c1;
endmodule

module mul2x2_seq_ctrl #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_y,
    output logic             busy
);
    localparam int D    = W / 2;
    localparam int N    = D * D;
    localparam int IDXW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IDXW-1:0] DMAX = IDXW'(D - 1);

    // Odd or too-small widths cannot be split into 2-bit digits.
    generate
        if ((W < 2) || ((W % 2) != 0) || (N < 1)) begin : g_bad_width
            $error("mul2x2_seq_ctrl: W must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_op_a;
    logic [W-1:0]      r_op_b;
    logic [2*W-1:0]    r_acc;
    logic [IDXW-1:0]   r_i;
    logic [IDXW-1:0]   r_j;
    logic [2*W-1:0]    r_out_y;
    logic              r_out_valid;

    logic [1:0]        w_dig_a;
    logic [1:0]        w_dig_b;
    logic [3:0]        w_p;
    logic [2*W-1:0]    w_p_ext;
    logic [IDXW:0]     w_sum;
    logic [IDXW+1:0]   w_shamt;
    logic [2*W-1:0]    w_term;
    logic [2*W-1:0]    w_acc_next;
    logic              w_last;

    // Digit i of A and digit j of B feed the shared multiplier.
    assign w_dig_a = r_op_a[{r_i, 1'b0} +: 2];
    assign w_dig_b = r_op_b[{r_j, 1'b0} +: 2];

    mul2x2_top u_mul (
        .a (w_dig_a),
        .b (w_dig_b),
        .p (w_p)
    );

    // Zero-extend the partial product and weight it by 4^(i+j).
    always_comb begin
        w_p_ext      = '0;
        w_p_ext[3:0] = w_p;
    end

    assign w_sum      = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt    = {w_sum, 1'b0};
    assign w_term     = w_p_ext << w_shamt;
    assign w_acc_next = r_acc + w_term;
    assign w_last     = (r_i == DMAX) && (r_j == DMAX);

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;

    // Control FSM: accept operands, walk the digit pairs, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_acc       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_out_y     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready is implied in IDLE, so in_valid alone accepts.
                    if (in_valid) begin
                        r_op_a  <= in_a;
                        r_op_b  <= in_b;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_out_y     <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_j == DMAX) begin
                        r_j <= '0;
                        r_i <= r_i + IDXW'(1);
                    end else begin
                        r_j <= r_j + IDXW'(1);
                    end
                end
                S_DONE: begin
                    // out_y is left untouched so the last product stays visible.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul2x2_seq_ctrl.sv
// Bench for mul2x2_seq_ctrl: directed scenarios plus a randomized run checked
// against a product scoreboard (a*b in plain arithmetic) and a fixed-latency model.
`timescale 1ns/1ps
module tb_mul2x2_seq_ctrl;
    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] out_y;

    logic        v2;
    logic        r2;
    logic [1:0]  a2;
    logic [1:0]  b2;
    logic        rdy2;
    logic        ov2;
    logic        busy2;
    logic [3:0]  y2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mul2x2_seq_ctrl #(.W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    mul2x2_seq_ctrl #(.W(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v2),
        .in_ready  (rdy2),
        .in_a      (a2),
        .in_b      (b2),
        .out_valid (ov2),
        .out_ready (r2),
        .out_y     (y2),
        .busy      (busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: accept one operand pair, wait for the result, then handshake.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] y, output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        y = '0;
        out_ready = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) tick();
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            y = out_y;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_total++;
        if ({out_valid, out_y, busy, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1})
            $display("FAIL reset_state: got v=%b y=%h busy=%b rdy=%b, need v=0 y=0000 busy=0 rdy=1",
                     out_valid, out_y, busy, in_ready);
        else n_pass++;
        tick();
        rst = 1'b0;
        n_total++;
        if ({ov2, y2, busy2, rdy2} !== {1'b0, 4'h0, 1'b0, 1'b1})
            $display("FAIL reset_state_w2: got v=%b y=%h busy=%b rdy=%b, need v=0 y=0 busy=0 rdy=1",
                     ov2, y2, busy2, rdy2);
        else n_pass++;
    endtask

    task automatic test_max;
        int cnt = 0;
        bit flags_ok = 1'b1;
        bit seen = 1'b0;
        logic [15:0] exp_y = 16'(8'hFF) * 16'(8'hFF);
        in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = 8'h00; in_b = 8'h00;
        for (int k = 0; k < 40; k++) begin
            if (!(in_ready === 1'b0 && busy === 1'b1)) flags_ok = 1'b0;
            tick();
            cnt++;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_total++;
        if (!seen || cnt != LAT) $display("FAIL max_latency: got %0d edges (seen=%0d), need %0d", cnt, seen, LAT);
        else n_pass++;
        n_total++;
        if (out_y !== exp_y) $display("FAIL max_product: got %h, need %h", out_y, exp_y);
        else n_pass++;
        n_total++;
        if (!flags_ok) $display("FAIL max_busy_flags: got in_ready/busy toggling during RUN, need 0/1");
        else n_pass++;
        tick();
        n_total++;
        if ({out_valid, in_ready, busy} !== 3'b010)
            $display("FAIL max_handshake: got v=%b rdy=%b busy=%b, need v=0 rdy=1 busy=0", out_valid, in_ready, busy);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0]  oa [2] = '{8'h12, 8'h80};
        logic [7:0]  ob [2] = '{8'h34, 8'h02};
        logic [15:0] res [2];
        int acc_cyc [2];
        int idx = 0;
        int nres = 0;
        bit wide = 1'b0;
        bit prev_v = 1'b0;
        bit acc_now;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (idx < 2) begin
                in_a = oa[idx]; in_b = ob[idx]; in_valid = 1'b1;
            end else in_valid = 1'b0;
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            if (out_valid) begin
                if (prev_v) wide = 1'b1;
                else if (nres < 2) begin
                    res[nres] = out_y;
                    nres++;
                end
            end
            prev_v = out_valid;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_total++;
        if (nres != 2 || idx != 2) $display("FAIL b2b_count: got %0d results %0d accepts, need 2 and 2", nres, idx);
        else n_pass++;
        n_total++;
        if (nres < 1 || res[0] !== 16'(oa[0]) * 16'(ob[0]))
            $display("FAIL b2b_first: got %h, need %h", res[0], 16'(oa[0]) * 16'(ob[0]));
        else n_pass++;
        n_total++;
        if (nres < 2 || res[1] !== 16'(oa[1]) * 16'(ob[1]))
            $display("FAIL b2b_second: got %h, need %h", res[1], 16'(oa[1]) * 16'(ob[1]));
        else n_pass++;
        n_total++;
        if (idx == 2 && (acc_cyc[1] - acc_cyc[0]) != LAT + 2)
            $display("FAIL b2b_spacing: got %0d edges, need %0d", acc_cyc[1] - acc_cyc[0], LAT + 2);
        else if (idx != 2) $display("FAIL b2b_spacing: got %0d accepts, need 2", idx);
        else n_pass++;
        n_total++;
        if (wide) $display("FAIL b2b_pulse_width: got out_valid wider than 1 cycle, need 1");
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [15:0] exp_y = 16'(8'h0D) * 16'(8'h0C);
        bit seen = 1'b0;
        bit hold_ok = 1'b1;
        out_ready = 1'b0;
        in_a = 8'h0D; in_b = 8'h0C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL bp_timeout: got no out_valid, need out_valid within 40 edges");
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0] ? 1'b0 : 1'b1;
            in_a = 8'($urandom); in_b = 8'($urandom);
            tick();
            if (!(out_valid === 1'b1 && out_y === exp_y && in_ready === 1'b0)) hold_ok = 1'b0;
        end
        in_valid = 1'b0;
        n_total++;
        if (!hold_ok) $display("FAIL bp_hold: got y=%h v=%b rdy=%b, need y=%h v=1 rdy=0", out_y, out_valid, in_ready, exp_y);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++;
        if ({out_valid, in_ready, out_y} !== {1'b0, 1'b1, exp_y})
            $display("FAIL bp_release: got v=%b rdy=%b y=%h, need v=0 rdy=1 y=%h", out_valid, in_ready, out_y, exp_y);
        else n_pass++;
        tick();
        n_total++;
        if ({in_ready, busy} !== 2'b10) $display("FAIL bp_pulses_ignored: got rdy=%b busy=%b, need rdy=1 busy=0", in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] y;
        int lat;
        bit ok;
        in_a = 8'hAB; in_b = 8'hCD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        n_total++;
        if ({out_valid, out_y, in_ready, busy} !== {1'b0, 16'h0000, 1'b1, 1'b0})
            $display("FAIL rst_mid_run: got v=%b y=%h rdy=%b busy=%b, need v=0 y=0000 rdy=1 busy=0",
                     out_valid, out_y, in_ready, busy);
        else n_pass++;
        #1;
        rst = 1'b0;
        do_op(8'h03, 8'h05, y, lat, ok);
        n_total++;
        if (!ok || y !== 16'(8'h03) * 16'(8'h05) || lat != LAT)
            $display("FAIL rst_followup: got y=%h lat=%0d ok=%0d, need y=%h lat=%0d", y, lat, ok,
                     16'(8'h03) * 16'(8'h05), LAT);
        else n_pass++;
    endtask

    task automatic test_zero;
        logic [15:0] y;
        int lat;
        bit ok;
        do_op(8'h00, 8'hAB, y, lat, ok);
        n_total++;
        if (!ok || y !== 16'h0000 || lat != LAT)
            $display("FAIL zero_operand: got y=%h lat=%0d ok=%0d, need y=0000 lat=%0d", y, lat, ok, LAT);
        else n_pass++;
    endtask

    task automatic test_w2;
        int cnt = 0;
        bit seen = 1'b0;
        logic [3:0] exp_y = 4'(2'd3) * 4'(2'd3);
        a2 = 2'd3; b2 = 2'd3; v2 = 1'b1; r2 = 1'b0;
        tick();
        v2 = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            cnt++;
            if (ov2) seen = 1'b1;
        end
        n_total++;
        if (!seen || cnt != 1 || y2 !== exp_y)
            $display("FAIL w2_product: got y=%h after %0d edges, need y=%h after 1", y2, cnt, exp_y);
        else n_pass++;
        r2 = 1'b1;
        tick();
        r2 = 1'b0;
        n_total++;
        if ({ov2, rdy2} !== 2'b01) $display("FAIL w2_handshake: got v=%b rdy=%b, need v=0 rdy=1", ov2, rdy2);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [15:0] exp_q [$];
        int accq [$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit prev_v = 1'b0;
        bit acc_now;
        bit del_now;
        logic [15:0] e;
        while (got < 1000 && cyc < 60000) begin
            if (sent < 1000 && $urandom_range(0, 9) < 6) begin
                in_valid = 1'b1;
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end else in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            acc_now = in_valid && in_ready;
            del_now = out_valid && out_ready;
            if (out_valid && !prev_v) begin
                n_total++;
                if (accq.size() == 0) $display("FAIL rnd_latency: got result with no accepted operands, need none");
                else if (cyc - accq[0] != LAT) $display("FAIL rnd_latency: got %0d edges, need %0d", cyc - accq[0], LAT);
                else n_pass++;
                if (accq.size() != 0) void'(accq.pop_front());
            end
            if (del_now) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL rnd_product: got %h, need no result", out_y);
                else begin
                    e = exp_q.pop_front();
                    if (out_y !== e) $display("FAIL rnd_product: got %h, need %h (result %0d)", out_y, e, got);
                    else n_pass++;
                end
                got++;
            end
            prev_v = out_valid;
            if (acc_now) begin
                exp_q.push_back(16'(in_a) * 16'(in_b));
                accq.push_back(cyc + 1);
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_total++;
        if (got != 1000 || sent != 1000 || exp_q.size() != 0)
            $display("FAIL rnd_totals: got %0d delivered %0d sent %0d pending, need 1000 1000 0", got, sent, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        v2 = 1'b0; r2 = 1'b0; a2 = '0; b2 = '0;
        test_reset();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_zero();
        test_w2();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
